// File: rtl/acc_rr_ctrl_pkg.sv
// Shared types and constants for the round-robin accumulator controller.
//   - ctrl_state_e : controller FSM states
//   - OP_ADD/OP_SUB: per-requester op encoding (matches accumulator mode input)
//   - ACC_W_DEF    : default accumulator width
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StSettle = 2'd2,
    StAck    = 2'd3
  } ctrl_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned ACC_W_DEF = 6;

endpackage

// File: rtl/acc_rr_ctrl_if.sv
// Bus bundle between the requesters/accumulator and the controller.
//   req, op    : per-requester request and op (requester side drives)
//   gnt        : one-hot completion ack (controller drives)
//   acc_show   : one-cycle strobe to the accumulator
//   acc_mode   : op presented to the accumulator while acc_show is high
//   acc_val    : accumulator output (accumulator drives)
//   res        : captured result, held until the next completion
//   wrap, rej  : completion status pulses, coincident with gnt
//   busy       : controller is not idle
// Modports: master = requesters + accumulator side, slave = controller.
interface acc_rr_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ACC_W   = 6
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] op;
  logic [NUM_REQ-1:0] gnt;
  logic               acc_show;
  logic               acc_mode;
  logic [ACC_W-1:0]   acc_val;
  logic [ACC_W-1:0]   res;
  logic               wrap;
  logic               rej;
  logic               busy;

  modport master (
    output req, op, acc_val,
    input  gnt, acc_show, acc_mode, res, wrap, rej, busy
  );

  modport slave (
    input  req, op, acc_val,
    output gnt, acc_show, acc_mode, res, wrap, rej, busy
  );
endinterface

// File: rtl/acc_rr_ctrl_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   pointer : highest-priority index this round
//   valid   : at least one request is set
//   winner  : first set index at or above pointer, wrapping modulo NUM_REQ
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  // Scan from the farthest offset down so the closest request to the pointer
  // is the last assignment and therefore wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[(32'(pointer) + 32'(i)) % NUM_REQ]) begin
        valid  = 1'b1;
        winner = IDX_W'((32'(pointer) + 32'(i)) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/acc_rr_ctrl.sv
// Round-robin controller sharing one add/sub accumulator between NUM_REQ
// requesters. Serialises requests, strobes the accumulator, waits SETTLE
// cycles, then acks the winner with the captured result.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : acc_rr_ctrl_if.slave (req/op in, gnt/acc_show/acc_mode/res/wrap/rej/busy
//         out, acc_val in)
// Build option: define ACC_SAT_EN to suppress ops that would wrap; they are
// acked immediately with rej instead of being issued to the accumulator.
module acc_rr_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned SETTLE  = 1
) (
  input logic          clk,
  input logic          rst,
  acc_rr_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_e        state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    win_q;
  logic               op_q;
  logic [ACC_W-1:0]   pre_q;
  logic [2:0]         cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               show_q;
  logic               mode_q;
  logic [ACC_W-1:0]   res_q;
  logic               wrap_q;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_op;
  logic               pre_wrap;
  logic [IdxW-1:0]    ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_pick (
    .req     (bus.req),
    .pointer (ptr_q),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  assign pick_op = bus.op[pick_idx];

  // Wrap is judged purely on the value seen before the op was issued.
  assign pre_wrap = ((op_q == OP_ADD) && (pre_q == {ACC_W{1'b1}})) ||
                    ((op_q == OP_SUB) && (pre_q == '0));

  assign ptr_next = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef ACC_SAT_EN
  logic rej_q;
  logic idle_wrap;

  assign idle_wrap = ((pick_op == OP_ADD) && (bus.acc_val == {ACC_W{1'b1}})) ||
                     ((pick_op == OP_SUB) && (bus.acc_val == '0));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_ADD;
      pre_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      show_q  <= 1'b0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef ACC_SAT_EN
      rej_q   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only the cycle entering a state raises them.
      gnt_q  <= '0;
      show_q <= 1'b0;
      wrap_q <= 1'b0;
`ifdef ACC_SAT_EN
      rej_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            win_q <= pick_idx;
            op_q  <= pick_op;
            pre_q <= bus.acc_val;
`ifdef ACC_SAT_EN
            if (idle_wrap) begin
              state_q <= StAck;
              gnt_q   <= NUM_REQ'(1) << pick_idx;
              rej_q   <= 1'b1;
              res_q   <= bus.acc_val;
            end else begin
              state_q <= StIssue;
              show_q  <= 1'b1;
              mode_q  <= pick_op;
            end
`else
            state_q <= StIssue;
            show_q  <= 1'b1;
            mode_q  <= pick_op;
`endif
          end
        end
        StIssue: begin
          state_q <= StSettle;
          cnt_q   <= 3'(SETTLE - 1);
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StAck;
            gnt_q   <= NUM_REQ'(1) << win_q;
            res_q   <= bus.acc_val;
            wrap_q  <= pre_wrap;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          ptr_q   <= ptr_next;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.acc_show = show_q;
  assign bus.acc_mode = mode_q;
  assign bus.res      = res_q;
  assign bus.wrap     = wrap_q;
  assign bus.busy     = (state_q != StIdle);
`ifdef ACC_SAT_EN
  assign bus.rej      = rej_q;
`else
  assign bus.rej      = 1'b0;
`endif

endmodule

// File: tb/tb_acc_rr_ctrl.sv
// Scoreboard bench for acc_rr_ctrl: stimulus pushes expected show strobes and
// grants; a negedge monitor pops and compares whenever the DUT presents them.
module tb_acc_rr_ctrl;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned ST = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_rr_ctrl_if #(.NUM_REQ(NR), .ACC_W(AW)) bus ();

  acc_rr_ctrl #(
    .NUM_REQ (NR),
    .ACC_W   (AW),
    .SETTLE  (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NR-1:0] gnt;
    logic [AW-1:0] res;
    logic          wrap;
    logic          rej;
    int            cyc;
  } gnt_exp_t;

  typedef struct {
    logic mode;
    int   cyc;
  } show_exp_t;

  gnt_exp_t  gq[$];
  show_exp_t sq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Accumulator model: loadable for setup, otherwise steps on each show strobe.
  logic [AW-1:0] acc    = '0;
  logic [AW-1:0] ld_val = '0;
  logic          ld     = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) acc <= ld_val;
    else if (bus.acc_show) acc <= bus.acc_mode ? acc - 1'b1 : acc + 1'b1;
  end

  assign bus.acc_val = acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.acc_show) begin
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL show_unexpected: acc_show=1 expected none (cycle %0d)", cyc);
        end else begin
          show_exp_t e;
          e = sq.pop_front();
          chk("show_mode", 32'(bus.acc_mode), 32'(e.mode));
          chk("show_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.gnt != '0) begin
        if (gq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL gnt_unexpected: gnt=%b expected none (cycle %0d)", bus.gnt, cyc);
        end else begin
          gnt_exp_t g;
          g = gq.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(g.gnt));
          chk("res", 32'(bus.res), 32'(g.res));
          chk("wrap", 32'(bus.wrap), 32'(g.wrap));
          chk("rej", 32'(bus.rej), 32'(g.rej));
          chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
        end
      end else begin
        chk("pulse_without_gnt", {30'd0, bus.wrap, bus.rej}, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_acc(input logic [AW-1:0] v);
    ld_val = v;
    ld     = 1'b1;
    step();
    ld     = 1'b0;
  endtask

  task automatic exp_show(input logic m, input int c);
    show_exp_t e;
    e.mode = m;
    e.cyc  = c;
    sq.push_back(e);
  endtask

  task automatic exp_gnt(input logic [NR-1:0] g, input logic [AW-1:0] r, input logic w,
                         input logic j, input int c);
    gnt_exp_t e;
    e.gnt  = g;
    e.res  = r;
    e.wrap = w;
    e.rej  = j;
    e.cyc  = c;
    gq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.req = '0;
    bus.op  = '0;
    rst     = 1'b0;
    repeat (2) step();
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_show", 32'(bus.acc_show), 32'd0);
    chk("rst_mode", 32'(bus.acc_mode), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    chk("rst_rej", 32'(bus.rej), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    step();
    rst = 1'b1;

    // Single add from 5.
    set_acc(6'd5);
    c = cyc;
    bus.op  = 4'b0000;
    bus.req = 4'b0001;
    exp_show(1'b0, c + 1);
    exp_gnt(4'b0001, 6'd6, 1'b0, 1'b0, c + 3);
    wait_to(c + 1);
    #1 chk("busy_issue", 32'(bus.busy), 32'd1);
    wait_to(c + 3);
    bus.req = '0;
    step();
    #1 chk("busy_idle", 32'(bus.busy), 32'd0);

    // Reset clears res and pointer before the fairness sweep.
    step();
    rst = 1'b0;
    #1 chk("res_after_rst", 32'(bus.res), 32'd0);
    step();
    rst = 1'b1;

    // All four requesting: strict rotation from 0, acc 6 -> 11.
    c = cyc;
    bus.op  = 4'b0000;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_show(1'b0, c + 1 + 4 * k);
      exp_gnt(4'(1 << (k % 4)), 6'(7 + k), 1'b0, 1'b0, c + 3 + 4 * k);
    end
    wait_to(c + 19);
    bus.req = '0;

    // Add at max (pointer now 1).
    step();
    set_acc(6'd63);
    c = cyc;
    bus.op  = 4'b0000;
    bus.req = 4'b0010;
`ifdef ACC_SAT_EN
    exp_gnt(4'b0010, 6'd63, 1'b0, 1'b1, c + 1);
    wait_to(c + 1);
`else
    exp_show(1'b0, c + 1);
    exp_gnt(4'b0010, 6'd0, 1'b1, 1'b0, c + 3);
    wait_to(c + 3);
`endif
    bus.req = '0;

    // Sub at zero (pointer now 2).
    step();
    set_acc(6'd0);
    c = cyc;
    bus.op  = 4'b0100;
    bus.req = 4'b0100;
`ifdef ACC_SAT_EN
    exp_gnt(4'b0100, 6'd0, 1'b0, 1'b1, c + 1);
    wait_to(c + 1);
`else
    exp_show(1'b1, c + 1);
    exp_gnt(4'b0100, 6'd63, 1'b1, 1'b0, c + 3);
    wait_to(c + 3);
`endif
    bus.req = '0;
    bus.op  = '0;

    // Pointer 3: req[2] wins, drops during SETTLE; req[1] raised then, served next.
    step();
    set_acc(6'd20);
    c = cyc;
    bus.req = 4'b0100;
    exp_show(1'b0, c + 1);
    exp_gnt(4'b0100, 6'd21, 1'b0, 1'b0, c + 3);
    wait_to(c + 2);
    bus.req = 4'b0010;
    exp_show(1'b0, c + 5);
    exp_gnt(4'b0010, 6'd22, 1'b0, 1'b0, c + 7);
    wait_to(c + 7);
    bus.req = '0;

    // Reset during ISSUE aborts the op (pointer was 2, req[0] wins).
    step();
    c = cyc;
    bus.req = 4'b0001;
    exp_show(1'b0, c + 1);
    wait_to(c + 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_show", 32'(bus.acc_show), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    bus.req = '0;
    wait_to(c + 2);
    rst = 1'b1;
    wait_to(c + 3);
    #1;
    chk("abort_no_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_acc_kept", 32'(acc), 32'd22);

    // Pointer back at 0: with req 0101, 0 wins first, then 2.
    step();
    c = cyc;
    bus.op  = 4'b0000;
    bus.req = 4'b0101;
    exp_show(1'b0, c + 1);
    exp_gnt(4'b0001, 6'd23, 1'b0, 1'b0, c + 3);
    exp_show(1'b0, c + 5);
    exp_gnt(4'b0100, 6'd24, 1'b0, 1'b0, c + 7);
    wait_to(c + 3);
    bus.req = 4'b0100;
    wait_to(c + 7);
    bus.req = '0;

    repeat (4) step();
    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("show_queue_drained", 32'(sq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
